phys_reg_free_list: RTL and testbench

//  Rename-stage free list of physical register ids for the RV64 out-of-order core. Hands one free

---
 rtl/phys_reg_free_list_pkg.sv | 25 ++
 rtl/phys_reg_free_list_in_use_map.sv | 42 ++++
 rtl/phys_reg_free_list.sv | 107 ++++++++++
 tb/tb_phys_reg_free_list.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/phys_reg_free_list_pkg.sv
// Shared types and constants for the physical register free list.
// Optional feature macro: FREELIST_DUP_CHECK_EN (used by phys_reg_free_list).
package phys_reg_free_list_pkg;

    localparam int unsigned NUM_PHYS_REGS = 128;
    localparam int unsigned NUM_ARCH_REGS = 32;

    typedef logic Boolean_T;

    typedef struct packed {
        logic       valid;
        logic [6:0] id;
    } PhyRegisterId_T;

    // Bit [7] is the wrap bit, so full and empty are distinguishable.
    typedef logic [7:0] FreeListPtr_T;

    function automatic PhyRegisterId_T mk_phy_id(input logic [6:0] id);
        PhyRegisterId_T r;
        r.valid = 1'b1;
        r.id    = id;
        return r;
    endfunction

endpackage

// File: rtl/phys_reg_free_list_in_use_map.sv
// phys_reg_in_use_map: tracks which physical ids are architecturally committed, so
// that a release of an id that is already free can be rejected.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   set_valid      commit_alloc: mark set_id in use
//   set_id         id being committed
//   clr_valid      accepted release: mark clr_id free
//   clr_id         id being released (also the lookup index)
//   in_use_hit     in_use[clr_id] from registered state
module phys_reg_in_use_map
    import phys_reg_free_list_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  Boolean_T   set_valid,
    input  logic [6:0] set_id,
    input  Boolean_T   clr_valid,
    input  logic [6:0] clr_id,
    output Boolean_T   in_use_hit
);

    logic [NUM_PHYS_REGS-1:0] in_use_q;
    logic [NUM_PHYS_REGS-1:0] in_use_d;

    assign in_use_hit = in_use_q[clr_id];

    always_comb begin
        in_use_d = in_use_q;
        if (set_valid) in_use_d[set_id] = 1'b1;
        if (clr_valid) in_use_d[clr_id] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Architectural ids 0..NUM_ARCH_REGS-1 are mapped at reset.
            in_use_q <= {{(NUM_PHYS_REGS - NUM_ARCH_REGS){1'b0}}, {NUM_ARCH_REGS{1'b1}}};
        end else begin
            in_use_q <= in_use_d;
        end
    end

endmodule

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list: circular free list of physical register ids for the renamer.
// A speculative head serves allocations; a committed head follows ROB commit so a
// flush rewinds all wrong-path allocations in one cycle.
// Configuration: define FREELIST_DUP_CHECK_EN to reject releases of ids that are
// not in use (dup_err pulses for one cycle); otherwise dup_err is tied 0.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   alloc_req/alloc_gnt  allocation handshake, alloc_id valid iff not empty
//   commit_alloc         oldest committing instruction had allocated a register
//   rel_valid, rel_id    release of the previous mapping at commit
//   flush                rewind speculative head to committed head
//   free_count, empty    speculative free entries
//   dup_err              illegal release pulse (registered)
module phys_reg_free_list
    import phys_reg_free_list_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  Boolean_T       alloc_req,
    output Boolean_T       alloc_gnt,
    output PhyRegisterId_T alloc_id,
    input  Boolean_T       commit_alloc,
    input  Boolean_T       rel_valid,
    input  PhyRegisterId_T rel_id,
    input  Boolean_T       flush,
    output logic [7:0]     free_count,
    output Boolean_T       empty,
    output Boolean_T       dup_err
);

    logic [6:0]   fl_q [NUM_PHYS_REGS];
    FreeListPtr_T spec_head_q, spec_head_d;
    FreeListPtr_T cmt_head_q, cmt_head_d;
    FreeListPtr_T tail_q, tail_d;
    FreeListPtr_T total;
    Boolean_T     full;
    Boolean_T     rel_req;
    Boolean_T     rel_accept;

    assign free_count = tail_q - spec_head_q;
    assign empty      = (free_count == 8'd0);
    assign total      = tail_q - cmt_head_q;
    assign full       = (total == 8'(NUM_PHYS_REGS));
    assign alloc_gnt  = alloc_req & ~empty & ~flush;
    assign alloc_id   = empty ? PhyRegisterId_T'(8'h00) : mk_phy_id(fl_q[spec_head_q[6:0]]);
    assign rel_req    = rel_valid & rel_id.valid;

`ifdef FREELIST_DUP_CHECK_EN
    Boolean_T in_use_hit;
    Boolean_T dup_err_q;

    phys_reg_in_use_map u_in_use_map (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_valid  (commit_alloc),
        .set_id     (fl_q[cmt_head_q[6:0]]),
        .clr_valid  (rel_accept),
        .clr_id     (rel_id.id),
        .in_use_hit (in_use_hit)
    );

    assign rel_accept = rel_req & ~full & in_use_hit;
    assign dup_err    = dup_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dup_err_q <= 1'b0;
        end else begin
            dup_err_q <= rel_req & ~rel_accept;
        end
    end
`else
    assign rel_accept = rel_req & ~full;
    assign dup_err    = 1'b0;
`endif

    always_comb begin
        cmt_head_d  = cmt_head_q + FreeListPtr_T'(commit_alloc);
        tail_d      = tail_q + FreeListPtr_T'(rel_accept);
        spec_head_d = spec_head_q + FreeListPtr_T'(alloc_gnt);
        // Rewind lands on the committed head including this cycle's commit.
        if (flush) spec_head_d = cmt_head_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spec_head_q <= '0;
            cmt_head_q  <= '0;
            tail_q      <= 8'(NUM_PHYS_REGS - NUM_ARCH_REGS);
        end else begin
            spec_head_q <= spec_head_d;
            cmt_head_q  <= cmt_head_d;
            tail_q      <= tail_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PHYS_REGS; i++) begin
                fl_q[i] <= (i < NUM_PHYS_REGS - NUM_ARCH_REGS) ? 7'(NUM_ARCH_REGS + i) : 7'd0;
            end
        end else if (rel_accept) begin
            fl_q[tail_q[6:0]] <= rel_id.id;
        end
    end

endmodule

// File: tb/tb_phys_reg_free_list.sv
module tb_phys_reg_free_list;
    import phys_reg_free_list_pkg::*;

    logic           clk;
    logic           rst_n;
    Boolean_T       alloc_req;
    Boolean_T       alloc_gnt;
    PhyRegisterId_T alloc_id;
    Boolean_T       commit_alloc;
    Boolean_T       rel_valid;
    PhyRegisterId_T rel_id;
    Boolean_T       flush;
    logic [7:0]     free_count;
    Boolean_T       empty;
    Boolean_T       dup_err;

    phys_reg_free_list dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alloc_req    (alloc_req),
        .alloc_gnt    (alloc_gnt),
        .alloc_id     (alloc_id),
        .commit_alloc (commit_alloc),
        .rel_valid    (rel_valid),
        .rel_id       (rel_id),
        .flush        (flush),
        .free_count   (free_count),
        .empty        (empty),
        .dup_err      (dup_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FREELIST_DUP_CHECK_EN
    localparam bit DupEn = 1'b1;
`else
    localparam bit DupEn = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Model: queue holds every id from the committed head to the tail, in order;
    // spec_off is how many of those have been handed out speculatively.
    int unsigned q_ids[$];
    int          spec_off;
    bit          in_use_m[128];
    bit          exp_dup;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic model_reset();
        q_ids.delete();
        for (int i = 32; i < 128; i++) q_ids.push_back(i);
        spec_off = 0;
        for (int i = 0; i < 128; i++) in_use_m[i] = (i < 32);
        exp_dup = 1'b0;
    endtask

    function automatic int m_free();
        return q_ids.size() - spec_off;
    endfunction

    function automatic logic [7:0] m_id();
        if (m_free() == 0) return 8'h00;
        return 8'h80 | 8'(q_ids[spec_off]);
    endfunction

    function automatic bit m_gnt();
        return alloc_req && (m_free() != 0) && !flush;
    endfunction

    // Compare all outputs against the model, away from the active edge.
    task automatic sample();
        @(negedge clk);
        check("free_count", 32'(free_count), 32'(m_free()));
        check("empty", 32'(empty), 32'(m_free() == 0));
        check("alloc_id", 32'(alloc_id), 32'(m_id()));
        check("alloc_gnt", 32'(alloc_gnt), 32'(m_gnt()));
        check("dup_err", 32'(dup_err), 32'(exp_dup));
    endtask

    task automatic advance();
        bit gnt;
        bit req;
        bit ok;
        int unsigned cid;
        @(posedge clk);
        gnt = m_gnt();
        req = rel_valid && rel_id.valid;
        ok  = req && (q_ids.size() < 128) && (!DupEn || in_use_m[rel_id.id]);
        exp_dup = DupEn && req && !ok;
        if (commit_alloc) begin
            assert (spec_off > 0) else $error("commit_alloc with no outstanding allocation");
            cid = q_ids.pop_front();
            in_use_m[cid] = 1'b1;
            spec_off = spec_off - 1;
        end
        if (ok) begin
            q_ids.push_back(int'(rel_id.id));
            in_use_m[rel_id.id] = 1'b0;
        end
        if (flush) spec_off = 0;
        else if (gnt) spec_off = spec_off + 1;
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic idle_inputs();
        alloc_req = 0; commit_alloc = 0; rel_valid = 0; rel_id = 8'h00; flush = 0;
    endtask

    // Called just after a posedge; reset pulse finishes before the next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        #2;
        model_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12 rst_n = 1'b1;

        // Reset state
        sample();
        check("rst_free", 32'(free_count), 32'd96);
        check("rst_empty", 32'(empty), 32'd0);
        check("rst_id", 32'(alloc_id), 32'hA0);
        check("rst_dup", 32'(dup_err), 32'd0);
        advance();

        // Drain the list: 96 grants A0..FF, then empty
        alloc_req = 1;
        for (int i = 0; i < 97; i++) begin
            sample();
            if (i < 96) begin
                check("drain_gnt", 32'(alloc_gnt), 32'd1);
                check("drain_id", 32'(alloc_id), 32'hA0 + 32'(i));
            end else begin
                check("empty_gnt", 32'(alloc_gnt), 32'd0);
                check("empty_flag", 32'(empty), 32'd1);
                check("empty_id", 32'(alloc_id), 32'h00);
            end
            advance();
        end

        // Release from empty: not allocatable until the next cycle
        rel_valid = 1; rel_id = 8'h85;
        sample();
        check("rel_cycle_gnt", 32'(alloc_gnt), 32'd0);
        advance();
        rel_valid = 0; rel_id = 8'h00;
        sample();
        check("rel_next_gnt", 32'(alloc_gnt), 32'd1);
        check("rel_next_id", 32'(alloc_id), 32'h85);
        advance();
        sample();
        check("rel_after_free", 32'(free_count), 32'd0);
        alloc_req = 0;
        advance();

        // Alloc x3, commit, flush
        do_reset();
        alloc_req = 1;
        repeat (3) cycle();
        alloc_req = 0; commit_alloc = 1;
        cycle();
        commit_alloc = 0; flush = 1;
        cycle();
        flush = 0;
        sample();
        check("flush_free", 32'(free_count), 32'd95);
        check("flush_id", 32'(alloc_id), 32'hA1);
        advance();
        flush = 1; alloc_req = 1;
        sample();
        check("flush_beats_alloc", 32'(alloc_gnt), 32'd0);
        advance();
        flush = 0;
        cycle();
        // alloc + commit + release in one cycle
        commit_alloc = 1; rel_valid = 1; rel_id = 8'h82;
        cycle();
        idle_inputs();
        cycle();
        cycle();

        // Asynchronous reset mid-sequence
        do_reset();
        alloc_req = 1;
        repeat (10) cycle();
        rst_n = 1'b0;
        alloc_req = 0;
        #2;
        check("mid_rst_free", 32'(free_count), 32'd96);
        check("mid_rst_id", 32'(alloc_id), 32'hA0);
        check("mid_rst_empty", 32'(empty), 32'd0);
        check("mid_rst_gnt", 32'(alloc_gnt), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        cycle();

        // Release of a free id (37), then of an architectural id (3)
        rel_valid = 1; rel_id = 8'hA5;
        cycle();
        rel_id = 8'h83;
        sample();
        check("dup_pulse", 32'(dup_err), DupEn ? 32'd1 : 32'd0);
        check("dup_free", 32'(free_count), DupEn ? 32'd96 : 32'd97);
        advance();
        rel_valid = 0; rel_id = 8'h00;
        sample();
        check("dup_clear", 32'(dup_err), 32'd0);
        check("arch_rel_free", 32'(free_count), DupEn ? 32'd97 : 32'd98);
        advance();

        // Fill to 128 then a release must be dropped
        do_reset();
        for (int i = 0; i < 32; i++) begin
            rel_valid = 1; rel_id = 8'(8'h80 + i);
            cycle();
        end
        rel_id = 8'h90;
        sample();
        check("full_free", 32'(free_count), 32'd128);
        advance();
        rel_valid = 0; rel_id = 8'h00;
        sample();
        check("full_drop_free", 32'(free_count), 32'd128);
        check("full_drop_dup", 32'(dup_err), DupEn ? 32'd1 : 32'd0);
        advance();
        alloc_req = 1;
        repeat (3) cycle();
        idle_inputs();
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
